// File: rtl/sha3_absorb_pad.sv
// ---------------------------------------------------------------------------
// sha3_absorb_pad
//
// Absorb-side front end of the SHA3-256 sponge. Message bytes arrive as
// little-endian 64-bit words. They are packed into a rate-sized block buffer,
// padded with the SHA3 domain byte and the closing 0x80 bit, and XORed onto
// the running 1600-bit state. That state is handed to the Keccak-f
// permutation, and the permuted result is absorbed back. After the final
// block the state is held for the squeeze stage until it is acknowledged.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid_i          message word valid
//   in_ready_o          a word is accepted this cycle when valid is also high
//   in_data_i           message word, byte k = bits [8k+7:8k]
//   in_last_i           this is the final word of the message
//   in_bytes_i          number of valid low bytes in the word (0..8)
//   perm_req_o          perm_state_out_o is valid, permutation requested
//   perm_state_out_o    sponge state XOR zero-extended block buffer
//   perm_ack_i          one-cycle pulse, perm_state_in_i is valid
//   perm_state_in_i     permuted state returned by Keccak-f
//   digest_valid_o      absorbed state is ready for squeeze
//   digest_state_o      final sponge state, stable while digest_valid_o
//   digest_ack_i        squeeze consumed the state; clear and rearm
// ---------------------------------------------------------------------------
module sha3_absorb_pad #(
    parameter int         RATE_LANES  = 17,
    parameter logic [7:0] DOMAIN_BYTE = 8'h06
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [63:0]   in_data_i,
    input  logic          in_last_i,
    input  logic [3:0]    in_bytes_i,
    output logic          perm_req_o,
    output logic [1599:0] perm_state_out_o,
    input  logic          perm_ack_i,
    input  logic [1599:0] perm_state_in_i,
    output logic          digest_valid_o,
    output logic [1599:0] digest_state_o,
    input  logic          digest_ack_i
);

    localparam int RATE_BITS  = 64 * RATE_LANES;
    localparam int RATE_BYTES = 8 * RATE_LANES;
    localparam int LW         = $clog2(RATE_LANES);
    localparam int PW         = $clog2(RATE_BYTES + 1);

    localparam logic [1:0] ST_ABSORB = 2'd0;
    localparam logic [1:0] ST_PAD    = 2'd1;
    localparam logic [1:0] ST_PERM   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]           state_q,      state_d;
    logic [1599:0]        s_q,          s_d;
    logic [RATE_BITS-1:0] b_q,          b_d;
    logic [LW-1:0]        laneCnt_q,    laneCnt_d;
    logic [PW-1:0]        padPos_q,     padPos_d;
    logic                 padPending_q, padPending_d;
    logic                 final_q,      final_d;

    logic [63:0]          wordMasked;

    // Keep only the valid low bytes of the incoming word; the rest become
    // zero so stale upper bytes can never leak into the block.
    always_comb begin
        wordMasked = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < in_bytes_i) begin
                wordMasked[8*k +: 8] = in_data_i[8*k +: 8];
            end
        end
    end

    // Next-state logic for the FSM, the block buffer and the sponge state.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        b_d          = b_q;
        laneCnt_d    = laneCnt_q;
        padPos_d     = padPos_q;
        padPending_d = padPending_q;
        final_d      = final_q;

        case (state_q)
            ST_ABSORB: begin
                if (in_valid_i) begin
                    for (int i = 0; i < RATE_LANES; i++) begin
                        if (laneCnt_q == LW'(i)) begin
                            b_d[64*i +: 64] = wordMasked;
                        end
                    end
                    if (in_last_i) begin
                        // Byte index just past the message inside this block.
                        padPos_d = PW'({laneCnt_q, 3'b000}) + PW'(in_bytes_i);
                        state_d  = ST_PAD;
                    end else begin
                        laneCnt_d = laneCnt_q + LW'(1);
                        if (laneCnt_q == LW'(RATE_LANES - 1)) begin
                            final_d = 1'b0;
                            state_d = ST_PERM;
                        end
                    end
                end
            end

            ST_PAD: begin
                if (padPos_q == PW'(RATE_BYTES)) begin
                    // Message filled the rate exactly: padding needs a whole
                    // extra block, injected after this permutation returns.
                    padPending_d = 1'b1;
                    final_d      = 1'b0;
                end else begin
                    // When the pad position is the last rate byte both XORs
                    // land on the same byte and merge into 0x86.
                    for (int k = 0; k < RATE_BYTES; k++) begin
                        if (padPos_q == PW'(k)) begin
                            b_d[8*k +: 8] = b_d[8*k +: 8] ^ DOMAIN_BYTE;
                        end
                    end
                    b_d[RATE_BITS-8 +: 8] = b_d[RATE_BITS-8 +: 8] ^ 8'h80;
                    final_d = 1'b1;
                end
                state_d = ST_PERM;
            end

            ST_PERM: begin
                if (perm_ack_i) begin
                    s_d       = perm_state_in_i;
                    b_d       = '0;
                    laneCnt_d = '0;
                    if (final_q) begin
                        final_d = 1'b0;
                        state_d = ST_DONE;
                    end else if (padPending_q) begin
                        b_d[7:0]              = DOMAIN_BYTE;
                        b_d[RATE_BITS-8 +: 8] = 8'h80;
                        padPending_d          = 1'b0;
                        final_d               = 1'b1;
                    end else begin
                        state_d = ST_ABSORB;
                    end
                end
            end

            ST_DONE: begin
                if (digest_ack_i) begin
                    s_d     = '0;
                    state_d = ST_ABSORB;
                end
            end

            default: begin
                state_d = ST_ABSORB;
            end
        endcase
    end

    // State registers; reset abandons any message in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ABSORB;
            s_q          <= '0;
            b_q          <= '0;
            laneCnt_q    <= '0;
            padPos_q     <= '0;
            padPending_q <= 1'b0;
            final_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            b_q          <= b_d;
            laneCnt_q    <= laneCnt_d;
            padPos_q     <= padPos_d;
            padPending_q <= padPending_d;
            final_q      <= final_d;
        end
    end

    // Ready is gated by reset so nothing is accepted while reset is held,
    // even though the state register already sits in ABSORB.
    assign in_ready_o       = (state_q == ST_ABSORB) && rst_n;
    assign perm_req_o       = (state_q == ST_PERM);
    assign digest_valid_o   = (state_q == ST_DONE);
    assign perm_state_out_o = s_q ^ 1600'(b_q);
    assign digest_state_o   = s_q;

endmodule

// File: tb/tb_sha3_absorb_pad.sv
// ---------------------------------------------------------------------------
// tb_sha3_absorb_pad
//
// Drives messages into sha3_absorb_pad and plays the role of both the
// Keccak-f permutation (returning random states) and the squeeze stage.
// Expected block contents come from a byte-level SHA3 padding model:
// message bytes followed by 0x06 ... 0x80 up to a multiple of 136 bytes.
// ---------------------------------------------------------------------------
module tb_sha3_absorb_pad;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic          perm_req;
    logic [1599:0] perm_state_out;
    logic          perm_ack;
    logic [1599:0] perm_state_in;
    logic          digest_valid;
    logic [1599:0] digest_state;
    logic          digest_ack;

    int            checkCount = 0;
    int            errorCount = 0;

    logic [7:0]    msg    [0:543];
    logic [7:0]    padded [0:543];
    int            msgLen;
    int            paddedLen;
    int            numBlocks;
    logic [1599:0] sModel;
    logic [1599:0] firstOut;
    int            permCount;
    int            permDelay;

    sha3_absorb_pad dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_data_i        (in_data),
        .in_last_i        (in_last),
        .in_bytes_i       (in_bytes),
        .perm_req_o       (perm_req),
        .perm_state_out_o (perm_state_out),
        .perm_ack_i       (perm_ack),
        .perm_state_in_i  (perm_state_in),
        .digest_valid_o   (digest_valid),
        .digest_state_o   (digest_state),
        .digest_ack_i     (digest_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; reports the lowest differing 64-bit lane.
    task automatic checkOutput(input string tag, input logic [1599:0] actual,
                               input logic [1599:0] expected);
        int bad;
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            bad = 0;
            for (int i = 24; i >= 0; i--) begin
                if (actual[64*i +: 64] !== expected[64*i +: 64]) bad = i;
            end
            $display("[TB] FAIL %s lane %0d got %h expected %h", tag, bad,
                     actual[64*bad +: 64], expected[64*bad +: 64]);
        end
    endtask

    function automatic logic [1599:0] randState();
        logic [1599:0] r;
        for (int i = 0; i < 50; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic setRandomMsg(input int len);
        msgLen = len;
        for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
    endtask

    // SHA3 multi-rate padding at byte level.
    task automatic buildModel();
        paddedLen = (msgLen / 136 + 1) * 136;
        for (int i = 0; i < paddedLen; i++) padded[i] = (i < msgLen) ? msg[i] : 8'h00;
        padded[msgLen]      = padded[msgLen] ^ 8'h06;
        padded[paddedLen-1] = padded[paddedLen-1] ^ 8'h80;
        numBlocks = paddedLen / 136;
    endtask

    function automatic logic [1599:0] expectedOut(input int b);
        logic [1599:0] e;
        e = sModel;
        for (int k = 0; k < 136; k++) e[8*k +: 8] = e[8*k +: 8] ^ padded[b*136 + k];
        return e;
    endfunction

    // Message feeder; valid stays high while the block is stalled.
    task automatic applyStimulus();
        int nWords;
        int nb;
        int cnt;
        logic [63:0] d;
        logic last;
        nWords = (msgLen == 0) ? 1 : (msgLen + 7) / 8;
        for (int w = 0; w < nWords; w++) begin
            last = (w == nWords - 1);
            nb   = last ? msgLen - 8 * w : 8;
            for (int k = 0; k < 8; k++) begin
                d[8*k +: 8] = (k < nb) ? msg[8*w + k] : 8'($urandom);
            end
            in_valid = 1'b1;
            in_data  = d;
            in_last  = last;
            in_bytes = 4'(nb);
            cnt = 0;
            while (in_ready !== 1'b1 && cnt < 300) begin
                @(negedge clk);
                cnt++;
            end
            checkOutput("inReadySeen", in_ready, 1'b1);
            @(negedge clk);
            if (last) begin
                in_valid = 1'b0;
                checkOutput("padCycleNoReq", perm_req, 1'b0);
                @(negedge clk);
                checkOutput("finalReqLatency", perm_req, 1'b1);
            end else if (w % 17 == 16) begin
                checkOutput("blockReqLatency", perm_req, 1'b1);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Permutation and squeeze responder.
    task automatic servePerms();
        int cnt;
        int d;
        logic [1599:0] exp;
        logic [1599:0] newS;
        logic [1599:0] held;
        for (int b = 0; b < numBlocks; b++) begin
            cnt = 0;
            while (perm_req !== 1'b1 && cnt < 300) begin
                @(negedge clk);
                cnt++;
            end
            checkOutput("permReqSeen", perm_req, 1'b1);
            exp = expectedOut(b);
            checkOutput("permStateOut", perm_state_out, exp);
            if (permCount == 0) firstOut = perm_state_out;
            permCount++;
            checkOutput("inReadyLowInPerm", in_ready, 1'b0);
            d = (permDelay < 0) ? int'($urandom_range(0, 4)) : permDelay;
            repeat (d) begin
                @(negedge clk);
                checkOutput("permOutStable", perm_state_out, exp);
                checkOutput("permReqHeld", perm_req, 1'b1);
                checkOutput("inReadyHeldLow", in_ready, 1'b0);
            end
            newS          = randState();
            perm_state_in = newS;
            perm_ack      = 1'b1;
            @(negedge clk);
            perm_ack      = 1'b0;
            perm_state_in = randState();
            sModel        = newS;
            if (b == numBlocks - 1) begin
                checkOutput("digestValidAfterFinal", digest_valid, 1'b1);
            end else if (b == numBlocks - 2 && paddedLen - msgLen == 136) begin
                checkOutput("padBlockReqAgain", perm_req, 1'b1);
            end else begin
                checkOutput("backToAbsorb", in_ready, 1'b1);
            end
        end
        checkOutput("digestState", digest_state, sModel);
        checkOutput("noReqInDone", perm_req, 1'b0);
        held     = digest_state;
        perm_ack = 1'b1;
        @(negedge clk);
        perm_ack = 1'b0;
        checkOutput("ackIgnoredInDone", digest_state, sModel);
        checkOutput("digestHeld", digest_valid, 1'b1);
        digest_ack = 1'b1;
        @(negedge clk);
        digest_ack = 1'b0;
        sModel     = '0;
        checkOutput("digestCleared", digest_valid, 1'b0);
        checkOutput("stateCleared", digest_state, sModel);
        checkOutput("rearmed", in_ready, 1'b1);
        if (held !== digest_state) permCount = permCount;
    endtask

    task automatic runMessage();
        buildModel();
        permCount = 0;
        fork
            applyStimulus();
            servePerms();
        join
    endtask

    task automatic setAbc();
        msgLen = 3;
        msg[0] = 8'h61;
        msg[1] = 8'h62;
        msg[2] = 8'h63;
    endtask

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        in_last       = 1'b0;
        in_bytes      = '0;
        perm_ack      = 1'b0;
        perm_state_in = '0;
        digest_ack    = 1'b0;
        sModel        = '0;
        permDelay     = -1;

        repeat (2) @(negedge clk);
        checkOutput("rstInReady", in_ready, 1'b0);
        checkOutput("rstPermReq", perm_req, 1'b0);
        checkOutput("rstDigestValid", digest_valid, 1'b0);
        checkOutput("rstPermOut", perm_state_out, '0);
        checkOutput("rstDigestState", digest_state, '0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterReset", in_ready, 1'b1);

        // Empty message
        msgLen = 0;
        runMessage();
        checkOutput("emptyLane0", firstOut[63:0], 64'h06);
        checkOutput("emptyLane16", firstOut[1087:1024], 64'h8000_0000_0000_0000);
        checkOutput("emptyPerms", permCount, 1);

        // "abc"
        setAbc();
        runMessage();
        checkOutput("abcLane0", firstOut[63:0], 64'h0000_0000_0663_6261);
        checkOutput("abcLane16", firstOut[1087:1024], 64'h8000_0000_0000_0000);

        // 135 bytes: merged pad byte
        setRandomMsg(135);
        runMessage();
        checkOutput("len135Byte135", firstOut[1087:1080], 8'h86);
        checkOutput("len135Perms", permCount, 1);

        // 136 bytes: padding spills into a whole extra block
        setRandomMsg(136);
        runMessage();
        checkOutput("len136Perms", permCount, 2);

        // Backpressure: every permutation acknowledged 5 cycles late
        permDelay = 5;
        setRandomMsg(200);
        runMessage();
        permDelay = -1;

        // Random lengths
        for (int t = 0; t < 6; t++) begin
            setRandomMsg(int'($urandom_range(0, 300)));
            runMessage();
        end

        // Reset while a 136-byte message waits in PERM
        setRandomMsg(136);
        buildModel();
        applyStimulus();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstPermReq", perm_req, 1'b0);
        checkOutput("midRstInReady", in_ready, 1'b0);
        checkOutput("midRstDigestValid", digest_valid, 1'b0);
        checkOutput("midRstPermOut", perm_state_out, '0);
        checkOutput("midRstDigestState", digest_state, '0);
        @(negedge clk);
        rst_n  = 1'b1;
        sModel = '0;
        @(negedge clk);
        setAbc();
        runMessage();
        checkOutput("abcAfterRstLane0", firstOut[63:0], 64'h0000_0000_0663_6261);
        checkOutput("abcAfterRstLane16", firstOut[1087:1024], 64'h8000_0000_0000_0000);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
